// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: the carry chain is cut into STAGES equal slices,
// each resolved in its own register stage. Valid/ready on both sides with
// bubble-collapsing advance, one result per clock when the sink keeps up.
//
// Optional feature macro: PIPELINED_ADDER_SUB_EN
//   defined   -> extra 'sub' input; sub=1 computes a - b (cin ignored)
//   undefined -> pure addition a + b + cin
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready input handshake; a, b, cin (and sub) sampled on transfer
//   out_valid/out_ready output handshake
//   sum, cout, ovf    result, carry out of MSB, signed overflow
module pipelined_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SLICE = WIDTH / STAGES;
  localparam int unsigned MSB   = WIDTH - 1;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
    $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  // Per-stage state: valid, carry out of the last resolved slice, partial sum
  // and the operands still carrying unresolved upper bits.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic              ovf_q, ovf_d;

  // Effective B and carry-in at the pipeline entry.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef PIPELINED_ADDER_SUB_EN
  always_comb begin
    b_eff   = sub ? ~b : b;
    cin_eff = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    b_eff   = b;
    cin_eff = cin;
  end
`endif

  // Advance rule: a stage may load when its successor is empty or moves on.
  logic [STAGES-1:0] load;

  always_comb begin
    load = '0;
    load[STAGES-1] = !valid_q[STAGES-1] || out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      load[k] = !valid_q[k+1] || load[k+1];
    end
  end

  assign in_ready = load[0];

  // Upstream view for each stage: the input port for stage 0, the previous
  // stage's registers otherwise.
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] src_carry;
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [WIDTH-1:0]  src_sum [STAGES];

  always_comb begin
    src_valid    = '0;
    src_carry    = '0;
    src_valid[0] = in_valid;
    src_carry[0] = cin_eff;
    src_a[0]     = a;
    src_b[0]     = b_eff;
    src_sum[0]   = '0;
    for (int k = 1; k < int'(STAGES); k++) begin
      src_valid[k] = valid_q[k-1];
      src_carry[k] = carry_q[k-1];
      src_a[k]     = a_q[k-1];
      src_b[k]     = b_q[k-1];
      src_sum[k]   = sum_q[k-1];
    end
  end

  // Stage next-state: resolve slice k on entry to stage k.
  logic [SLICE:0] slice_res;

  always_comb begin
    valid_d   = valid_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    slice_res = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      sum_d[k] = sum_q[k];
    end
    for (int k = 0; k < int'(STAGES); k++) begin
      slice_res = (SLICE+1)'(src_a[k][k*SLICE +: SLICE])
                + (SLICE+1)'(src_b[k][k*SLICE +: SLICE])
                + (SLICE+1)'(src_carry[k]);
      if (load[k]) begin
        // Loading with nothing upstream leaves the stage empty (a bubble).
        valid_d[k] = src_valid[k];
        if (src_valid[k]) begin
          a_d[k]   = src_a[k];
          b_d[k]   = src_b[k];
          sum_d[k] = src_sum[k];
          sum_d[k][k*SLICE +: SLICE] = slice_res[SLICE-1:0];
          carry_d[k] = slice_res[SLICE];
          // The top slice produces the final sum MSB, so overflow is known here.
          if (k == int'(STAGES) - 1) begin
            ovf_d = (src_a[k][MSB] == src_b[k][MSB]) &&
                    (slice_res[SLICE-1] != src_a[k][MSB]);
          end
        end
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  // Last stage drives the result directly.
  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=16, STAGES=4): reset, carry
// propagation/latency, overflow, streaming, backpressure, reset mid-flight
// and (with PIPELINED_ADDER_SUB_EN) subtraction.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
`ifdef PIPELINED_ADDER_SUB_EN
  logic        sub = 1'b0;
`endif
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PIPELINED_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Reference: {ovf, cout, sum} from a full-width add.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic s);
    logic [15:0] ye;
    logic        ce;
    logic [16:0] full;
    logic        v;
    ye   = s ? ~y : y;
    ce   = s ? 1'b1 : c;
    full = 17'(x) + 17'(ye) + 17'(ce);
    v    = (x[15] == ye[15]) && (full[15] != x[15]);
    return {v, full[16], full[15:0]};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++;
    if ({ovf, cout, sum} !== 18'h0) begin
      fails++; $display("FAIL reset_result: got ovf=%b cout=%b sum=%h exp 0/0/0000", ovf, cout, sum);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_carry_chain();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL carry_in_ready: got %b exp 1", in_ready); end
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (n == 4) begin
        if (out_valid !== 1'b1 || {ovf, cout, sum} !== {1'b0, 1'b1, 16'h0000}) begin
          fails++;
          $display("FAIL carry_result: got v=%b ovf=%b cout=%b sum=%h exp v=1 0/1/0000",
                   out_valid, ovf, cout, sum);
        end
      end else if (out_valid !== 1'b0) begin
        fails++; $display("FAIL carry_latency: cycle %0d got out_valid=%b exp 0", n, out_valid);
      end
    end
  endtask

  task automatic test_overflow();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 16'h7FFF; b = 16'h0001; cin = 1'b0;
    @(negedge clk);
    a = 16'h8000; b = 16'h8000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || {ovf, cout, sum} !== {1'b1, 1'b0, 16'h8000}) begin
      fails++; $display("FAIL ovf_pos: got v=%b ovf=%b cout=%b sum=%h exp v=1 1/0/8000", out_valid, ovf, cout, sum);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || {ovf, cout, sum} !== {1'b1, 1'b1, 16'h0000}) begin
      fails++; $display("FAIL ovf_neg: got v=%b ovf=%b cout=%b sum=%h exp v=1 1/1/0000", out_valid, ovf, cout, sum);
    end
    @(negedge clk);
  endtask

  task automatic test_streaming();
    logic [15:0] va [20];
    logic [15:0] vb [20];
    logic        vc [20];
    logic [17:0] ex [20];
    for (int i = 0; i < 20; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
      vc[i] = 1'($urandom);
      ex[i] = model(va[i], vb[i], vc[i], 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = va[0]; b = vb[0]; cin = vc[0];
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (n < 20) begin
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready: cycle %0d got %b exp 1", n, in_ready); end
        a = va[n]; b = vb[n]; cin = vc[n];
      end else begin
        in_valid = 1'b0;
      end
      checks++;
      if (n >= 4 && n < 24) begin
        if (out_valid !== 1'b1 || {ovf, cout, sum} !== ex[n-4]) begin
          fails++; $display("FAIL stream_result: idx %0d got v=%b %h exp v=1 %h", n-4, out_valid, {ovf, cout, sum}, ex[n-4]);
        end
      end else if (out_valid !== 1'b0) begin
        fails++; $display("FAIL stream_idle: cycle %0d got out_valid=%b exp 0", n, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] sb[$];
    logic [17:0] front;
    int sent = 0;
    int got  = 0;
    for (int c = 0; c < 80 && got < 8; c++) begin
      @(negedge clk);
      out_ready = (c < 5) || (c >= 12);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        a   = 16'(sent * 16'h2345 + 16'h0F0F);
        b   = 16'(16'hF00F ^ (sent * 16'h0F31));
        cin = 1'(sent);
      end
      #1;
      if (c == 8) begin
        checks++;
        if (in_ready !== 1'b0 || sent != 5) begin
          fails++; $display("FAIL bp_full: got in_ready=%b accepted=%0d exp in_ready=0 accepted=5", in_ready, sent);
        end
      end
      if (out_valid) begin
        front = (sb.size() > 0) ? sb[0] : 18'h3FFFF;
        checks++;
        if (sb.size() == 0 || {ovf, cout, sum} !== front) begin
          fails++; $display("FAIL bp_result: cycle %0d got %h exp %h (pending %0d)", c, {ovf, cout, sum}, front, sb.size());
        end
        if (out_ready && sb.size() > 0) begin
          void'(sb.pop_front());
          got++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(a, b, cin, 1'b0));
        sent++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (got != 8 || sb.size() != 0) begin
      fails++; $display("FAIL bp_count: got %0d results, %0d pending, exp 8 and 0", got, sb.size());
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'(16'h1000 + i); b = 16'h0101; cin = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b exp 0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_in_ready: got %b exp 1", in_ready); end
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_flush: cycle %0d got out_valid=%b exp 0", n, out_valid); end
    end
  endtask

`ifdef PIPELINED_ADDER_SUB_EN
  task automatic test_subtract();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; sub = 1'b1; a = 16'h0005; b = 16'h0007; cin = 1'b0;
    @(negedge clk);
    a = 16'h8000; b = 16'h0001; cin = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; sub = 1'b0; cin = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || {ovf, cout, sum} !== {1'b0, 1'b0, 16'hFFFE}) begin
      fails++; $display("FAIL sub_borrow: got v=%b ovf=%b cout=%b sum=%h exp v=1 0/0/FFFE", out_valid, ovf, cout, sum);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || {ovf, cout, sum} !== {1'b1, 1'b1, 16'h7FFF}) begin
      fails++; $display("FAIL sub_ovf: got v=%b ovf=%b cout=%b sum=%h exp v=1 1/1/7FFF", out_valid, ovf, cout, sum);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_carry_chain();
    test_overflow();
    test_streaming();
    test_backpressure();
    test_reset_midflight();
`ifdef PIPELINED_ADDER_SUB_EN
    test_subtract();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
